// File: rtl/riscv_pkg.sv
// Shared RV32I constants: ALU op encodings, opcodes, operand-select codes and
// the decoded bundle types passed from decode to execute.
package riscv_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] A_SEL_RS1  = 2'd0;
    localparam logic [1:0] A_SEL_PC   = 2'd1;
    localparam logic [1:0] A_SEL_ZERO = 2'd2;
    localparam logic       B_SEL_RS2  = 1'b0;
    localparam logic       B_SEL_IMM  = 1'b1;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic [1:0]  a_sel;
        logic        b_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_we;
        logic        illegal;
    } dec_t;

    typedef struct packed {
        dec_t        dec;
        logic [31:0] pc;
    } bundle_t;

endpackage

// File: rtl/alu_dec_comb.sv
// Pure combinational RV32I decoder: raw instruction in, ALU control bundle out.
module alu_dec_comb
    import riscv_pkg::*;
(
    input  logic [31:0] inst,
    output dec_t        dec
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    logic        writes_rd;
    logic        ill;
    dec_t        d;

    assign opc   = inst[6:0];
    assign f3    = inst[14:12];
    assign f7    = inst[31:25];
    assign i_imm = {{20{inst[31]}}, inst[31:20]};
    assign s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign b_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign u_imm = {inst[31:12], 12'h000};
    assign j_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        d         = '0;
        d.alu_op  = ALU_ADD;
        writes_rd = 1'b0;
        ill       = 1'b0;
        case (opc)
            OPC_OP: begin
                d.rs1 = inst[19:15];
                d.rs2 = inst[24:20];
                d.rd  = inst[11:7];
                writes_rd = 1'b1;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  d.alu_op = ALU_ADD;
                        3'b001:  d.alu_op = ALU_SLL;
                        3'b010:  d.alu_op = ALU_SLT;
                        3'b011:  d.alu_op = ALU_SLTU;
                        3'b100:  d.alu_op = ALU_XOR;
                        3'b101:  d.alu_op = ALU_SRL;
                        3'b110:  d.alu_op = ALU_OR;
                        default: d.alu_op = ALU_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    d.alu_op = ALU_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    d.alu_op = ALU_SRA;
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_OPIMM: begin
                d.rs1   = inst[19:15];
                d.rd    = inst[11:7];
                d.b_sel = B_SEL_IMM;
                d.imm   = i_imm;
                writes_rd = 1'b1;
                case (f3)
                    3'b000: d.alu_op = ALU_ADD;
                    3'b010: d.alu_op = ALU_SLT;
                    3'b011: d.alu_op = ALU_SLTU;
                    3'b100: d.alu_op = ALU_XOR;
                    3'b110: d.alu_op = ALU_OR;
                    3'b111: d.alu_op = ALU_AND;
                    3'b001: begin
                        d.alu_op = ALU_SLL;
                        ill = (f7 != 7'b0000000);
                    end
                    default: begin
                        d.alu_op = f7[5] ? ALU_SRA : ALU_SRL;
                        ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                    end
                endcase
            end
            OPC_LUI, OPC_AUIPC: begin
                d.a_sel = (opc == OPC_LUI) ? A_SEL_ZERO : A_SEL_PC;
                d.b_sel = B_SEL_IMM;
                d.imm   = u_imm;
                d.rd    = inst[11:7];
                writes_rd = 1'b1;
            end
            OPC_JAL: begin
                d.a_sel = A_SEL_PC;
                d.b_sel = B_SEL_IMM;
                d.imm   = j_imm;
                d.rd    = inst[11:7];
                writes_rd = 1'b1;
            end
            OPC_JALR, OPC_LOAD: begin
                d.rs1   = inst[19:15];
                d.b_sel = B_SEL_IMM;
                d.imm   = i_imm;
                d.rd    = inst[11:7];
                writes_rd = 1'b1;
            end
            OPC_STORE: begin
                d.rs1   = inst[19:15];
                d.rs2   = inst[24:20];
                d.b_sel = B_SEL_IMM;
                d.imm   = s_imm;
            end
            OPC_BRANCH: begin
                d.a_sel = A_SEL_PC;
                d.b_sel = B_SEL_IMM;
                d.imm   = b_imm;
                d.rs1   = inst[19:15];
                d.rs2   = inst[24:20];
            end
            default: ill = 1'b1;
        endcase
        // Illegal bundles carry no operands so execute only sees the exception flag.
        if (ill) begin
            d         = '0;
            d.illegal = 1'b1;
        end
        d.reg_we = writes_rd && (d.rd != 5'd0) && !ill;
    end

    assign dec = d;

endmodule

// File: rtl/alu_dec_stage.sv
// Decode pipeline stage: one output register plus optional skid entry, with
// valid/ready handshakes on both sides and flush from branch resolution.
module alu_dec_stage
    import riscv_pkg::*;
#(
    parameter bit          SKID     = 1'b1,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_alu_op,
    output logic [1:0]  out_a_sel,
    output logic        out_b_sel,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic        out_reg_we,
    output logic        out_illegal,
    output logic [31:0] out_pc
);

    localparam bundle_t EMPTY_B = '{dec: '0, pc: RESET_PC};

    dec_t    dec;
    bundle_t main_q, skid_q;
    logic    main_v, skid_v;
    logic    take, drain;

    alu_dec_comb u_dec (
        .inst (in_inst),
        .dec  (dec)
    );

    assign in_ready = SKID ? ~skid_v : (~main_v | out_ready);
    assign take     = in_valid & in_ready & ~flush;
    assign drain    = main_v & out_ready;

    // The skid entry only ever fills when main is stalled; with SKID=0 the
    // in_ready equation guarantees that never happens, so skid_v stays 0.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_v <= 1'b0;
            main_q <= EMPTY_B;
            skid_v <= 1'b0;
            skid_q <= EMPTY_B;
        end else if (skid_v) begin
            if (drain) begin
                main_q <= skid_q;
                skid_v <= 1'b0;
            end
        end else if (take) begin
            if (!main_v || drain) begin
                main_q <= '{dec: dec, pc: in_pc};
                main_v <= 1'b1;
            end else begin
                skid_q <= '{dec: dec, pc: in_pc};
                skid_v <= 1'b1;
            end
        end else if (drain) begin
            main_v <= 1'b0;
            main_q <= EMPTY_B;
        end
    end

    assign out_valid   = main_v;
    assign out_alu_op  = main_q.dec.alu_op;
    assign out_a_sel   = main_q.dec.a_sel;
    assign out_b_sel   = main_q.dec.b_sel;
    assign out_imm     = main_q.dec.imm;
    assign out_rs1     = main_q.dec.rs1;
    assign out_rs2     = main_q.dec.rs2;
    assign out_rd      = main_q.dec.rd;
    assign out_reg_we  = main_q.dec.reg_we;
    assign out_illegal = main_q.dec.illegal;
    assign out_pc      = main_q.pc;

endmodule
